// File: rtl/rv2t_mem_arbiter.sv
// rv2t_mem_arbiter: shares the single-port RAM between the RV2T core and the OCD port, with OCD priority limited by a streak count
// Ports: core_* and ocd_* are request/grant/read-return channels; mem_* drive the RAM (1-cycle read latency);
// sync_reset is synchronous and active-high; parameter MAX_OCD_STREAK bounds how long a waiting core can be passed over.
module rv2t_mem_arbiter #(
  parameter int ADDR_BITS      = 14,
  parameter int XLEN           = 32,
  parameter int MAX_OCD_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 core_req,
  input  logic [ADDR_BITS-1:0] core_addr,
  input  logic [XLEN/8-1:0]    core_we,
  input  logic [XLEN-1:0]      core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [XLEN-1:0]      core_rdata,
  input  logic                 ocd_req,
  input  logic [ADDR_BITS-1:0] ocd_addr,
  input  logic [XLEN/8-1:0]    ocd_we,
  input  logic [XLEN-1:0]      ocd_wdata,
  output logic                 ocd_gnt,
  output logic                 ocd_rvalid,
  output logic [XLEN-1:0]      ocd_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [XLEN/8-1:0]    mem_write_en,
  output logic [XLEN-1:0]      mem_write_data,
  input  logic [XLEN-1:0]      mem_read_data
);
  typedef enum logic [1:0] {NONE, CORE, OCD} owner_t;
  owner_t     rd_owner;
  logic [3:0] streak;
  logic       sat;
  assign sat = streak == 4'(MAX_OCD_STREAK);
  // rvalid is gated by sync_reset so a read granted just before reset is never reported
  always_comb begin
    ocd_gnt        = !sync_reset && ocd_req && !(core_req && sat);
    core_gnt       = !sync_reset && core_req && !ocd_gnt;
    mem_addr       = ocd_gnt ? ocd_addr : core_addr;
    mem_write_en   = ocd_gnt ? ocd_we : core_gnt ? core_we : '0;
    mem_write_data = ocd_gnt ? ocd_wdata : core_wdata;
    core_rvalid    = !sync_reset && rd_owner == CORE;
    ocd_rvalid     = !sync_reset && rd_owner == OCD;
    core_rdata     = core_rvalid ? mem_read_data : '0;
    ocd_rdata      = ocd_rvalid ? mem_read_data : '0;
  end
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rd_owner <= NONE;
      streak   <= '0;
    end else begin
      streak   <= (!core_req || core_gnt) ? 4'd0 : (ocd_gnt && !sat) ? streak + 4'd1 : streak;
      rd_owner <= (core_gnt && core_we == '0) ? CORE : (ocd_gnt && ocd_we == '0) ? OCD : NONE;
    end
  end
endmodule
